// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating counters and EX-stage redirect.
// Define BTB_STATS_EN to add saturating BranchCntE / MissCntE statistics outputs.
module branch_target_buffer #(
  parameter int ENTRY_BITS = 4
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] BranchCntE,
  output logic [31:0] MissCntE
`endif
);
  localparam int N  = 1 << ENTRY_BITS;
  localparam int TW = 30 - ENTRY_BITS;
  logic [N-1:0]          valid_q;
  logic [TW-1:0]         tag_q [N];
  logic [31:0]           target_q [N];
  logic [1:0]            ctr_q [N];
  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic                  hit_f, hit_e, upd, wr;
  logic [1:0]            ctr_d;
  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign hit_f = valid_q[idx_f] && tag_q[idx_f] == PCF[31:ENTRY_BITS+2];
  assign hit_e = valid_q[idx_e] && tag_q[idx_e] == PCE[31:ENTRY_BITS+2];
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
  assign upd = ValidE && BranchTypeE != 3'b000;
  assign wr  = upd && (hit_e || BranchE);
  assign MispredictE = upd && (PredTakenE != BranchE || (BranchE && PredTargetE != BranchTargetE));
  assign CorrectPCE  = BranchE ? BranchTargetE : PCE + 32'd4;
  // A miss only reaches here when taken, so it allocates weakly-taken.
  always_comb
    ctr_d = !hit_e ? 2'b10 :
            BranchE ? (ctr_q[idx_e] == 2'b11 ? 2'b11 : ctr_q[idx_e] + 2'd1) :
                      (ctr_q[idx_e] == 2'b00 ? 2'b00 : ctr_q[idx_e] - 2'd1);
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N)
    if (!CPU_RST_N) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
    end else if (wr) begin
      valid_q[idx_e] <= 1'b1;
      ctr_q[idx_e]   <= ctr_d;
    end
  // Tag and target carry no reset; valid_q masks them until allocated.
  always_ff @(posedge CPU_CLK)
    if (CPU_RST_N && upd && BranchE) begin
      target_q[idx_e] <= BranchTargetE;
      tag_q[idx_e]    <= PCE[31:ENTRY_BITS+2];
    end
`ifdef BTB_STATS_EN
  logic [31:0] bcnt_q, mcnt_q;
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N)
    if (!CPU_RST_N) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (upd && !(&bcnt_q)) bcnt_q <= bcnt_q + 32'd1;
      if (MispredictE && !(&mcnt_q)) mcnt_q <= mcnt_q + 32'd1;
    end
  assign BranchCntE = bcnt_q;
  assign MissCntE   = mcnt_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vector table, mid-run reset sequence, then random traffic
// checked against a PC-keyed reference model of the predictor.
module tb_branch_target_buffer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pcf = '0, pce = '0, btgt = '0, ptgt = '0;
  logic        ptk_f, valid_e = 1'b0, br_e = 1'b0, ptk_e = 1'b0, mis_e;
  logic [2:0]  bt_e = '0;
  logic [31:0] ptgt_f, cpc_e;
`ifdef BTB_STATS_EN
  logic [31:0] bcnt, mcnt;
`endif
  int n_cmp = 0, n_bad = 0;
  int unsigned m_bcnt = 0, m_mcnt = 0;
  logic [31:0] m_own [int];
  logic [31:0] m_tgt [int];
  int          m_ctr [int];

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRY_BITS(4)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .PCF(pcf), .PredTakenF(ptk_f), .PredTargetF(ptgt_f),
    .ValidE(valid_e), .BranchTypeE(bt_e), .BranchE(br_e), .PCE(pce), .BranchTargetE(btgt),
    .PredTakenE(ptk_e), .PredTargetE(ptgt), .MispredictE(mis_e), .CorrectPCE(cpc_e)
`ifdef BTB_STATS_EN
    , .BranchCntE(bcnt), .MissCntE(mcnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_stats(input string nm);
`ifdef BTB_STATS_EN
    chk({nm, " BranchCntE"}, bcnt, m_bcnt);
    chk({nm, " MissCntE"}, mcnt, m_mcnt);
`endif
  endtask

  typedef struct {
    logic [31:0] pcf; logic v; logic [2:0] bt; logic b; logic [31:0] pce, tgt;
    logic ptk; logic [31:0] ptgt;
    logic e_tk; logic [31:0] e_tgt; logic e_mis; logic [31:0] e_cpc;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(logic [31:0] pcf_, logic v, logic [2:0] bt, logic b,
                              logic [31:0] pce_, logic [31:0] tgt, logic ptk, logic [31:0] pt,
                              logic e_tk, logic [31:0] e_tgt, logic e_mis, logic [31:0] e_cpc);
    vec_t r;
    r.pcf = pcf_; r.v = v; r.bt = bt; r.b = b; r.pce = pce_; r.tgt = tgt; r.ptk = ptk;
    r.ptgt = pt; r.e_tk = e_tk; r.e_tgt = e_tgt; r.e_mis = e_mis; r.e_cpc = e_cpc;
    return r;
  endfunction

  // Reference model: an entry remembers the full branch PC that owns its slot.
  function automatic int slot(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction
  function automatic bit m_hit(logic [31:0] pc);
    return m_own.exists(slot(pc)) && (m_own[slot(pc)] >> 2) == (pc >> 2);
  endfunction
  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction
  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction
  function automatic void m_update(logic v, logic [2:0] bt, logic b, logic [31:0] pc,
                                   logic [31:0] tgt, logic mis);
    int k = slot(pc);
    if (v && bt != 0) begin
      m_bcnt++;
      if (m_hit(pc)) begin
        m_ctr[k] = b ? (m_ctr[k] == 3 ? 3 : m_ctr[k] + 1) : (m_ctr[k] == 0 ? 0 : m_ctr[k] - 1);
        if (b) m_tgt[k] = tgt;
      end else if (b) begin
        m_own[k] = pc;
        m_tgt[k] = tgt;
        m_ctr[k] = 2;
      end
    end
    if (mis) m_mcnt++;
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] hi;
    case ($urandom_range(0, 3))
      0: hi = 32'h0;
      1: hi = 32'h1;
      2: hi = 32'h5;
      default: hi = 32'h03FF_FFFF;
    endcase
    return (hi << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic drive(input vec_t t);
    pcf = t.pcf; valid_e = t.v; bt_e = t.bt; br_e = t.b; pce = t.pce;
    btgt = t.tgt; ptk_e = t.ptk; ptgt = t.ptgt;
  endtask

  initial begin
    // pcf   v  bt b  pce          tgt   ptk ptgt  e_tk e_tgt        e_mis e_cpc
    tbl.push_back(mk(32'h100, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 32'h4));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h0, 0, 32'h104, 1, 32'h80));
    tbl.push_back(mk(32'h100, 0, 1, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h104));
    tbl.push_back(mk(32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104));
    tbl.push_back(mk(32'h100, 1, 2, 0, 32'h100, 32'h80, 0, 32'h0, 0, 32'h104, 0, 32'h104));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h0, 0, 32'h104, 1, 32'h80));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h0, 0, 32'h104, 1, 32'h80));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80));
    tbl.push_back(mk(32'h100, 1, 7, 1, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80));
    tbl.push_back(mk(32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h84, 1, 32'h80, 1, 32'h104));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h100, 32'h88, 1, 32'h80, 1, 32'h80, 1, 32'h88));
    tbl.push_back(mk(32'h100, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h88, 0, 32'h4));
    tbl.push_back(mk(32'h100, 1, 1, 1, 32'h140, 32'h200, 0, 32'h0, 1, 32'h88, 1, 32'h200));
    tbl.push_back(mk(32'h100, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 32'h4));
    tbl.push_back(mk(32'h140, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h200, 0, 32'h4));
    tbl.push_back(mk(32'hFFFF_FFFC, 1, 1, 0, 32'hFFFF_FFFC, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    tbl.push_back(mk(32'hFFFF_FFFC, 1, 0, 1, 32'h1C0, 32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h300));
    tbl.push_back(mk(32'h1C0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h1C4, 0, 32'h4));
    tbl.push_back(mk(32'h140, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h200, 0, 32'h4));

    pcf = 32'h100;
    #1;
    chk("reset PredTakenF", 32'(ptk_f), 32'h0);
    chk("reset PredTargetF", ptgt_f, 32'h104);
    chk_stats("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d PredTakenF", i), 32'(ptk_f), 32'(tbl[i].e_tk));
      chk($sformatf("vec%0d PredTargetF", i), ptgt_f, tbl[i].e_tgt);
      chk($sformatf("vec%0d MispredictE", i), 32'(mis_e), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d CorrectPCE", i), cpc_e, tbl[i].e_cpc);
      chk_stats($sformatf("vec%0d", i));
      if (tbl[i].v && tbl[i].bt != 0) m_bcnt++;
      if (tbl[i].e_mis) m_mcnt++;
      @(posedge clk); #1;
    end

    // Mid-run asynchronous reset: clears at once and blocks an update under it.
    pcf = 32'h140; valid_e = 1'b1; bt_e = 3'd1; br_e = 1'b1; pce = 32'h180;
    btgt = 32'h500; ptk_e = 1'b0; ptgt = '0;
    #2 rst_n = 1'b0;
    #1;
    m_bcnt = 0; m_mcnt = 0;
    chk("midreset PredTakenF", 32'(ptk_f), 32'h0);
    chk("midreset PredTargetF", ptgt_f, 32'h144);
    chk_stats("midreset");
    @(posedge clk); #1;
    pcf = 32'h180;
    #1;
    chk("held reset no update", 32'(ptk_f), 32'h0);
    chk_stats("held reset");
    valid_e = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pcf = 32'h140;
    #1;
    chk("after reset entry gone", 32'(ptk_f), 32'h0);
    chk("after reset target", ptgt_f, 32'h144);

    for (int c = 0; c < 600; c++) begin
      logic exp_mis;
      logic [31:0] exp_cpc;
      pcf = rnd_pc();
      pce = rnd_pc();
      valid_e = $urandom_range(0, 7) != 0;
      bt_e = $urandom_range(0, 3) == 0 ? 3'd0 : 3'($urandom_range(1, 7));
      br_e = 1'($urandom_range(0, 1));
      btgt = 32'($urandom_range(0, 7)) << 4;
      if ($urandom_range(0, 3) != 0) begin
        ptk_e = m_taken(pce);
        ptgt = m_target(pce);
      end else begin
        ptk_e = 1'($urandom_range(0, 1));
        ptgt = 32'($urandom_range(0, 7)) << 4;
      end
      exp_mis = valid_e && bt_e != 0 && (ptk_e != br_e || (br_e && ptgt != btgt));
      exp_cpc = br_e ? btgt : pce + 32'd4;
      #1;
      chk($sformatf("rnd%0d PredTakenF", c), 32'(ptk_f), 32'(m_taken(pcf)));
      chk($sformatf("rnd%0d PredTargetF", c), ptgt_f, m_target(pcf));
      chk($sformatf("rnd%0d MispredictE", c), 32'(mis_e), 32'(exp_mis));
      chk($sformatf("rnd%0d CorrectPCE", c), cpc_e, exp_cpc);
      chk_stats($sformatf("rnd%0d", c));
      m_update(valid_e, bt_e, br_e, pce, btgt, exp_mis);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL provide parameter: ENTRY_BITS, 4, log2 of entry count (16 entries, index = PC[ENTRY_BITS+1:2], tag = PC[31:ENTRY_BITS+2]).
REQ-002 SHALL provide port: CPU_CLK  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: CPU_RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: PCF  in  32  fetch-stage PC to look up.
REQ-005 SHALL provide port: PredTakenF  out  1  prediction for PCF: taken.
REQ-006 SHALL provide port: PredTargetF  out  32  predicted next PC for PCF.
REQ-007 SHALL provide port: ValidE  in  1  EX-stage instruction valid (not flushed, not stalled).
REQ-008 SHALL provide port: BranchTypeE  in  3  EX branch type; 3'b000 = NOBRANCH, any other code = conditional branch.
REQ-009 SHALL provide port: BranchE  in  1  resolved outcome from the EX branch comparator, 1 = taken.
REQ-010 SHALL provide port: PCE, BranchTargetE  in  32 each  EX PC and computed branch target.
REQ-011 SHALL provide port: PredTakenE, PredTargetE  in  1/32  prediction made for this instruction, piped from IF.
REQ-012 SHALL provide port: MispredictE  out  1  redirect fetch this cycle.
REQ-013 SHALL provide port: CorrectPCE  out  32  redirect address.

Function
REQ-014 Entry state SHALL be: valid, tag, target[31:0], 2-bit saturating counter ctr.
REQ-015 Lookup SHALL be combinational from stored state: hitF = valid && tag match; PredTakenF = hitF && ctr[1]; PredTargetF = PredTakenF ? target : PCF+4 (mod 2^32).
REQ-016 Update SHALL occur on a rising edge only when ValidE=1 and BranchTypeE!=NOBRANCH; otherwise no state changes.
REQ-017 Update on hit at PCE: ctr saturating +1 if BranchE, else saturating -1 (floor 00, ceiling 11); target <= BranchTargetE when BranchE=1.
REQ-018 Update on miss with BranchE=1: allocate (overwrite) indexed entry with valid=1, tag from PCE, target=BranchTargetE, ctr=2'b10.
REQ-019 Update on miss with BranchE=0: no change.
REQ-020 Lookup and update on the same index in the same cycle: PredTakenF/PredTargetF SHALL reflect pre-update state (no bypass); new state visible the following cycle.
REQ-021 MispredictE SHALL = ValidE && BranchTypeE!=NOBRANCH && (PredTakenE!=BranchE || (BranchE && PredTargetE!=BranchTargetE)); 0 otherwise.
REQ-022 CorrectPCE SHALL = BranchE ? BranchTargetE : PCE+4 (mod 2^32), independent of MispredictE.
REQ-023 Latency: prediction 0 cycles; training effective 1 cycle after the update edge.

Reset
REQ-024 CPU_RST_N low SHALL immediately clear all valid bits, set all ctr to 2'b01 and zero all statistics counters; tags/targets need not reset.
REQ-025 During and after reset PredTakenF SHALL be 0 and PredTargetF = PCF+4; no update SHALL take effect while CPU_RST_N is low, including one asserted mid-operation.

Configuration
REQ-026 With macro BTB_STATS_EN defined SHALL add outputs BranchCntE[31:0] (+1 per qualifying update, REQ-016) and MissCntE[31:0] (+1 per cycle with MispredictE=1), both saturating at 32'hFFFF_FFFF.
REQ-027 Without BTB_STATS_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, PCF=32'h0000_0100 -> PredTakenF=0, PredTargetF=32'h0000_0104.
REQ-029 Update PCE=32'h100, BranchE=1, BranchTargetE=32'h80, PredTakenE=0 -> MispredictE=1, CorrectPCE=32'h80; next cycle PCF=32'h100 -> PredTakenF=1, PredTargetF=32'h80.
REQ-030 Same entry, two not-taken updates -> ctr 10->01->00, PredTakenF=0; four taken updates -> ctr 11, fifth leaves it 11.
REQ-031 Alias: PCE=32'h140 (same index, different tag) taken to 32'h200 after REQ-029 -> PCF=32'h100 misses (PredTakenF=0), PCF=32'h140 predicts 32'h200.
REQ-032 Correct prediction PredTakenE=1, PredTargetE=BranchTargetE=32'h80, BranchE=1 -> MispredictE=0; same with ValidE=0 and BranchE=0 -> MispredictE=0, no update.
REQ-033 PCE=32'hFFFF_FFFC, BranchE=0 -> CorrectPCE=32'h0000_0000; with BTB_STATS_EN, CPU_RST_N pulsed low mid-run -> BranchCntE=MissCntE=0 immediately.
